// File: rtl/sram_read_responder.sv
// Serves single-word SRAM reads for the VGA sampler (data valid two cycles after the request) and
// fills the SRAM from the frame writer in idle slots; reads always win and the sampler is never stalled.
module sram_read_responder #(
  parameter int AW     = 21,
  parameter int DW     = 32,
  parameter int WR_CYC = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW:1]   data_r_address,
  input  logic          data_r_req,
  output logic [DW-1:0] data_r,
  output logic          data_r_empty,
  input  logic          wr_req,
  input  logic [AW:1]   wr_address,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic [AW:1]   SRAM_A,
  input  logic [DW-1:0] SRAM_DQ_I,
  output logic [DW-1:0] SRAM_DQ_O,
  output logic          SRAM_DQ_OE,
  output logic          SRAM_CE_N,
  output logic          SRAM_OE_N,
  output logic          SRAM_WE_N
);

  localparam int CW = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYC - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_END} state_t;

  state_t        state, state_d;
  logic [CW-1:0] wr_cnt, wr_cnt_d;
  logic          pending, pending_d;
  logic [AW:1]   pend_addr, pend_addr_d;
  logic [DW-1:0] data_r_d, dq_o_d;
  logic [AW:1]   sram_a_d;
  logic          empty_d, wr_ack_d, dq_oe_d, ce_n_d, oe_n_d, we_n_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      pending      <= 1'b0;
      pend_addr    <= '0;
      data_r       <= '0;
      data_r_empty <= 1'b1;
      wr_ack       <= 1'b0;
      SRAM_A       <= '0;
      SRAM_DQ_O    <= '0;
      SRAM_DQ_OE   <= 1'b0;
      SRAM_CE_N    <= 1'b1;
      SRAM_OE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
    end else begin
      state        <= state_d;
      wr_cnt       <= wr_cnt_d;
      pending      <= pending_d;
      pend_addr    <= pend_addr_d;
      data_r       <= data_r_d;
      data_r_empty <= empty_d;
      wr_ack       <= wr_ack_d;
      SRAM_A       <= sram_a_d;
      SRAM_DQ_O    <= dq_o_d;
      SRAM_DQ_OE   <= dq_oe_d;
      SRAM_CE_N    <= ce_n_d;
      SRAM_OE_N    <= oe_n_d;
      SRAM_WE_N    <= we_n_d;
    end
  end

  always_comb begin
    state_d     = state;
    wr_cnt_d    = wr_cnt;
    pending_d   = pending;
    pend_addr_d = pend_addr;
    data_r_d    = data_r;
    empty_d     = data_r_empty;
    wr_ack_d    = 1'b0;
    sram_a_d    = SRAM_A;
    dq_o_d      = SRAM_DQ_O;
    dq_oe_d     = SRAM_DQ_OE;
    ce_n_d      = SRAM_CE_N;
    oe_n_d      = SRAM_OE_N;
    we_n_d      = SRAM_WE_N;

    // Any request arriving while the pins are busy becomes (or replaces) the pending read
    if (state != IDLE && data_r_req) begin
      pending_d   = 1'b1;
      pend_addr_d = data_r_address;
      empty_d     = 1'b1;
    end

    case (state)
      IDLE: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        if (data_r_req || pending) begin
          sram_a_d  = data_r_req ? data_r_address : pend_addr;
          ce_n_d    = 1'b0;
          oe_n_d    = 1'b0;
          empty_d   = 1'b1;
          pending_d = 1'b0;
          state_d   = RD;
        end else if (wr_req) begin
          sram_a_d = wr_address;
          dq_o_d   = wr_data;
          dq_oe_d  = 1'b1;
          ce_n_d   = 1'b0;
          we_n_d   = 1'b0;
          wr_cnt_d = '0;
          state_d  = WR;
        end
      end
      RD: begin
        data_r_d = SRAM_DQ_I;
        oe_n_d   = 1'b1;
        ce_n_d   = 1'b1;
        state_d  = IDLE;
        if (!data_r_req) empty_d = 1'b0;
      end
      WR: begin
        if (wr_cnt == WR_LAST) begin
          we_n_d   = 1'b1;
          ce_n_d   = 1'b1;
          wr_ack_d = 1'b1;
          state_d  = WR_END;
        end else begin
          wr_cnt_d = wr_cnt + CW'(1);
        end
      end
      WR_END: begin
        dq_oe_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_read_responder.sv
// Bench for sram_read_responder: behavioural async SRAM on the pins plus a read-data scoreboard.
`timescale 1ns/1ps
module tb_sram_read_responder;
  localparam int AW = 21;
  localparam int DW = 32;
  localparam int WR_CYC = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [AW:1]   data_r_address = '0;
  logic          data_r_req = 1'b0;
  logic [DW-1:0] data_r;
  logic          data_r_empty;
  logic          wr_req = 1'b0;
  logic [AW:1]   wr_address = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic [AW:1]   sram_a;
  logic [DW-1:0] sram_dq_i = '0;
  logic [DW-1:0] sram_dq_o;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  sram_read_responder #(.AW(AW), .DW(DW), .WR_CYC(WR_CYC)) dut (
    .CLK(CLK), .RST(RST),
    .data_r_address(data_r_address), .data_r_req(data_r_req),
    .data_r(data_r), .data_r_empty(data_r_empty),
    .wr_req(wr_req), .wr_address(wr_address), .wr_data(wr_data), .wr_ack(wr_ack),
    .SRAM_A(sram_a), .SRAM_DQ_I(sram_dq_i), .SRAM_DQ_O(sram_dq_o), .SRAM_DQ_OE(sram_dq_oe),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem [int];
  logic [DW-1:0] sb [$];
  int checks = 0, errors = 0;
  int we_cnt = 0, we_last = 0, we_total = 0;
  int oe_cnt = 0, oe_last = 0;
  int ack_cnt = 0;
  logic prev_empty = 1'b1;

  // Unwritten locations hold an address-derived pattern; 0x01234 is preloaded with a known word
  function automatic logic [DW-1:0] mem_rd(input logic [AW:1] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    if (a == 21'h01234) return 32'h00A1B2C3;
    return (32'(a) * 32'h9E3779B1) ^ 32'hC3C3C3C3;
  endfunction

  always @(negedge CLK) begin
    if (RST && !sram_we_n && !sram_ce_n && sram_dq_oe) mem[int'(sram_a)] = sram_dq_o;
    sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem_rd(sram_a) : '0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge, and retire any fresh read response
  task automatic tick();
    @(posedge CLK); #1;
    if (!sram_we_n) begin we_cnt++; we_total++; end
    else if (we_cnt != 0) begin we_last = we_cnt; we_cnt = 0; end
    if (sram_dq_oe) oe_cnt++;
    else if (oe_cnt != 0) begin oe_last = oe_cnt; oe_cnt = 0; end
    if (wr_ack) ack_cnt++;
    if (prev_empty && !data_r_empty) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: data_r=%0h with no read outstanding", data_r);
      end else begin
        check("rd_data", data_r, sb.pop_front());
      end
    end
    prev_empty = data_r_empty;
  endtask

  task automatic do_read(input logic [AW:1] a, input logic [DW-1:0] exp);
    data_r_req = 1'b1; data_r_address = a; sb.push_back(exp);
    tick();
    data_r_req = 1'b0;
    tick();
  endtask

  task automatic wait_ack(input string name);
    logic seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (wr_ack) seen = 1'b1;
    end
    wr_req = 1'b0;
    check(name, seen, 1'b1);
  endtask

  task automatic do_write(input logic [AW:1] a, input logic [DW-1:0] d);
    wr_req = 1'b1; wr_address = a; wr_data = d;
    wait_ack("wr_ack_seen");
    tick();
  endtask

  typedef struct {
    logic [AW:1]   addr;
    logic [DW-1:0] data;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, we0;
    tbl[0] = '{21'h1FFFFF, 32'hFFFFFFFF};
    tbl[1] = '{21'h000000, 32'h00000000};
    tbl[2] = '{21'h155555, 32'hA5A5A5A5};
    tbl[3] = '{21'h0AAAAA, 32'h5A5A5A5A};
    tbl[4] = '{21'h100000, 32'h80000001};
    tbl[5] = '{21'h000001, 32'h12345678};

    repeat (2) @(posedge CLK);
    #1;
    check("rst_ce_n", sram_ce_n, 1'b1);
    check("rst_oe_n", sram_oe_n, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_dq_oe", sram_dq_oe, 1'b0);
    check("rst_data_r", data_r, 32'h0);
    check("rst_empty", data_r_empty, 1'b1);
    check("rst_wr_ack", wr_ack, 1'b0);
    check("rst_sram_a", sram_a, 21'h0);
    check("rst_dq_o", sram_dq_o, 32'h0);
    RST = 1'b1;
    tick(); tick();

    // Single read: address on the pins one cycle after the request, data the cycle after
    data_r_req = 1'b1; data_r_address = 21'h01234; sb.push_back(32'h00A1B2C3);
    tick();
    data_r_req = 1'b0;
    check("t2_sram_a", sram_a, 21'h01234);
    check("t2_oe_n", sram_oe_n, 1'b0);
    check("t2_ce_n", sram_ce_n, 1'b0);
    tick();
    check("t2_empty", data_r_empty, 1'b0);
    tick();

    // Reset asserted while a read is on the pins
    data_r_req = 1'b1; data_r_address = 21'h00777;
    tick();
    data_r_req = 1'b0;
    #2; RST = 1'b0; #1;
    check("t1_ce_n", sram_ce_n, 1'b1);
    check("t1_oe_n", sram_oe_n, 1'b1);
    check("t1_we_n", sram_we_n, 1'b1);
    check("t1_dq_oe", sram_dq_oe, 1'b0);
    check("t1_data_r", data_r, 32'h0);
    check("t1_empty", data_r_empty, 1'b1);
    tick();
    RST = 1'b1;
    tick(); tick();

    // Write strobe timing and readback
    do_write(21'h1FFFF, 32'hDEADBEEF);
    tick(); tick();
    check("t6_we_low_cycles", we_last, 2);
    check("t6_dq_oe_cycles", oe_last, 3);
    do_read(21'h1FFFF, 32'hDEADBEEF);

    for (int i = 0; i < 6; i++) do_write(tbl[i].addr, tbl[i].data);
    for (int i = 0; i < 6; i++) do_read(tbl[i].addr, tbl[i].data);

    // Read and write requested in the same idle cycle
    a0 = ack_cnt;
    data_r_req = 1'b1; data_r_address = 21'h0AAAAA; sb.push_back(32'h5A5A5A5A);
    wr_req = 1'b1; wr_address = 21'h00200; wr_data = 32'hCAFEF00D;
    tick();
    data_r_req = 1'b0;
    check("t4_oe_n", sram_oe_n, 1'b0);
    check("t4_we_n", sram_we_n, 1'b1);
    check("t4_sram_a", sram_a, 21'h0AAAAA);
    wait_ack("t4_wr_ack_seen");
    repeat (3) tick();
    check("t4_ack_count", ack_cnt - a0, 1);
    do_read(21'h00200, 32'hCAFEF00D);

    // Read request arriving while a write holds the pins
    wr_req = 1'b1; wr_address = 21'h00300; wr_data = 32'h0BADC0DE;
    tick();
    check("t5_we_n", sram_we_n, 1'b0);
    data_r_req = 1'b1; data_r_address = 21'h00010; sb.push_back(mem_rd(21'h00010));
    tick();
    data_r_req = 1'b0;
    check("t5_empty_pending", data_r_empty, 1'b1);
    wait_ack("t5_wr_ack_seen");
    repeat (4) tick();
    check("t5_empty_after", data_r_empty, 1'b0);
    do_read(21'h00300, 32'h0BADC0DE);

    // Two requests during one write: only the newer one is answered
    wr_req = 1'b1; wr_address = 21'h00400; wr_data = 32'h44444444;
    tick();
    data_r_req = 1'b1; data_r_address = 21'h00020;
    tick();
    data_r_req = 1'b0;
    tick();
    check("t7_wr_ack", wr_ack, 1'b1);
    wr_req = 1'b0;
    data_r_req = 1'b1; data_r_address = 21'h00030; sb.push_back(mem_rd(21'h00030));
    tick();
    data_r_req = 1'b0;
    repeat (5) tick();

    // Raster streaming: a request every second cycle
    we0 = we_total;
    for (int i = 0; i < 512; i++) begin
      logic [AW:1] a;
      a = 21'h02000 + AW'(i);
      if (i > 0) check("t3_empty_slot", data_r_empty, 1'b0);
      data_r_req = 1'b1; data_r_address = a; sb.push_back(mem_rd(a));
      tick();
      data_r_req = 1'b0;
      tick();
    end
    tick();
    check("t3_we_quiet", we_total - we0, 0);

    repeat (4) tick();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
